// File: rtl/hpdmc_pkg.sv
// Shared definitions for the HPDMC command path: SDRAM command encodings,
// scheduler state encoding and address field widths.
package hpdmc_pkg;

  localparam int ROW_W  = 13;
  localparam int BANK_W = 2;
  localparam int NBANKS = 4;

  // {ras_n, cas_n, we_n}
  localparam logic [2:0] CMD_NOP   = 3'b111;
  localparam logic [2:0] CMD_ACT   = 3'b011;
  localparam logic [2:0] CMD_READ  = 3'b101;
  localparam logic [2:0] CMD_WRITE = 3'b100;
  localparam logic [2:0] CMD_PRE   = 3'b010;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_PRECHARGE = 3'd1;
  localparam logic [2:0] S_WAIT_RP   = 3'd2;
  localparam logic [2:0] S_ACTIVATE  = 3'd3;
  localparam logic [2:0] S_WAIT_RCD  = 3'd4;
  localparam logic [2:0] S_ISSUE     = 3'd5;

  function automatic logic [NBANKS-1:0] bank_onehot(input logic [BANK_W-1:0] b);
    return NBANKS'(1) << b;
  endfunction

endpackage

// File: rtl/hpdmc_openrows.sv
// Open-row table: one valid flag and one row address per bank, with a
// set/clear write port and a combinational open/hit lookup.
module hpdmc_openrows
  import hpdmc_pkg::*;
(
  input  logic              sys_clk,
  input  logic              sdram_rst,
  input  logic [BANK_W-1:0] bank,
  input  logic [ROW_W-1:0]  row,
  input  logic              set,
  input  logic              clr,
  output logic              is_open,
  output logic              hit
);

  logic [NBANKS-1:0] has_openrow;
  logic [ROW_W-1:0]  openrow [NBANKS];

  always_ff @(posedge sys_clk or posedge sdram_rst) begin
    if (sdram_rst) begin
      has_openrow <= '0;
    end else if (set) begin
      has_openrow[bank] <= 1'b1;
    end else if (clr) begin
      has_openrow[bank] <= 1'b0;
    end
  end

  // NOTE: the row storage carries no reset; has_openrow alone decides validity,
  // so resetting the array would only add reset fan-out.
  always_ff @(posedge sys_clk) begin
    if (set) openrow[bank] <= row;
  end

  assign is_open = has_openrow[bank];
  assign hit     = is_open && (openrow[bank] == row);

endmodule

// File: rtl/hpdmc_cmdsched.sv
// HPDMC command scheduler: turns one held memory access into the SDRAM
// PRE/ACT/READ/WRITE sequence, gated by the data-path timing controller.
module hpdmc_cmdsched
  import hpdmc_pkg::*;
#(
  parameter int sdram_depth       = 23,
  parameter int sdram_columndepth = 8
) (
  input  logic                   sys_clk,
  input  logic                   sdram_rst,
  input  logic                   stb,
  input  logic                   we,
  input  logic [sdram_depth-1:0] address,
  output logic                   ack,
  input  logic [2:0]             tim_rp,
  input  logic [2:0]             tim_rcd,
  input  logic                   read_safe,
  input  logic                   write_safe,
  input  logic [NBANKS-1:0]      precharge_safe,
  output logic                   read,
  output logic                   write,
  output logic [NBANKS-1:0]      concerned_bank,
  output logic                   sdram_cs_n,
  output logic                   sdram_ras_n,
  output logic                   sdram_cas_n,
  output logic                   sdram_we_n,
  output logic [ROW_W-1:0]       sdram_adr,
  output logic [BANK_W-1:0]      sdram_ba
);

  logic [sdram_columndepth-1:0] col;
  logic [BANK_W-1:0]            bank;
  logic [ROW_W-1:0]             row;
  logic [ROW_W-1:0]             col_adr;
  logic                         bank_open;
  logic                         row_hit;
  logic                         col_safe;
  logic [2:0]                   state;
  logic [2:0]                   cnt;

  assign col  = address[sdram_columndepth-1:0];
  assign bank = address[sdram_columndepth +: BANK_W];
  assign row  = address[sdram_depth-1 -: ROW_W];

  // Column address with A10 low: no auto-precharge, the row stays open.
  always_comb begin
    col_adr     = ROW_W'(col);
    col_adr[10] = 1'b0;
  end

  assign col_safe = we ? write_safe : read_safe;

  hpdmc_openrows u_openrows (
    .sys_clk   (sys_clk),
    .sdram_rst (sdram_rst),
    .bank      (bank),
    .row       (row),
    .set       (state == S_ACTIVATE),
    .clr       ((state == S_PRECHARGE) && precharge_safe[bank]),
    .is_open   (bank_open),
    .hit       (row_hit)
  );

  // NOTE: all state and outputs use non-blocking assignments so every branch
  // below sees the pre-edge values, whatever order the statements are in.
  always_ff @(posedge sys_clk or posedge sdram_rst) begin
    if (sdram_rst) begin
      state          <= S_IDLE;
      cnt            <= '0;
      sdram_cs_n     <= 1'b1;
      {sdram_ras_n, sdram_cas_n, sdram_we_n} <= CMD_NOP;
      sdram_adr      <= '0;
      sdram_ba       <= '0;
      ack            <= 1'b0;
      read           <= 1'b0;
      write          <= 1'b0;
      concerned_bank <= '0;
    end else begin
      sdram_cs_n     <= 1'b0;
      {sdram_ras_n, sdram_cas_n, sdram_we_n} <= CMD_NOP;
      ack            <= 1'b0;
      read           <= 1'b0;
      write          <= 1'b0;
      concerned_bank <= '0;

      case (state)
        S_IDLE: begin
          // The master still holds stb during the ack cycle; do not re-accept it.
          if (stb && !ack) begin
            if (row_hit)        state <= S_ISSUE;
            else if (bank_open) state <= S_PRECHARGE;
            else                state <= S_ACTIVATE;
          end
        end
        S_PRECHARGE: begin
          if (precharge_safe[bank]) begin
            {sdram_ras_n, sdram_cas_n, sdram_we_n} <= CMD_PRE;
            sdram_adr[10] <= 1'b0;
            sdram_ba      <= bank;
            cnt           <= tim_rp;
            state         <= S_WAIT_RP;
          end
        end
        S_WAIT_RP: begin
          if (cnt == 3'd0) state <= S_ACTIVATE;
          else             cnt   <= cnt - 3'd1;
        end
        S_ACTIVATE: begin
          {sdram_ras_n, sdram_cas_n, sdram_we_n} <= CMD_ACT;
          sdram_adr <= row;
          sdram_ba  <= bank;
          cnt       <= tim_rcd;
          state     <= S_WAIT_RCD;
        end
        S_WAIT_RCD: begin
          if (cnt == 3'd0) state <= S_ISSUE;
          else             cnt   <= cnt - 3'd1;
        end
        S_ISSUE: begin
          if (col_safe) begin
            {sdram_ras_n, sdram_cas_n, sdram_we_n} <= we ? CMD_WRITE : CMD_READ;
            sdram_adr      <= col_adr;
            sdram_ba       <= bank;
            ack            <= 1'b1;
            read           <= ~we;
            write          <= we;
            concerned_bank <= bank_onehot(bank);
            state          <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hpdmc_cmdsched.sv
// Directed bench for hpdmc_cmdsched: row hit/miss/closed sequences, safe-input
// stalls, reset mid-access and stb held across ack.
module tb_hpdmc_cmdsched;
  import hpdmc_pkg::*;

  logic        sys_clk;
  logic        sdram_rst;
  logic        stb;
  logic        we;
  logic [22:0] address;
  logic        ack;
  logic [2:0]  tim_rp;
  logic [2:0]  tim_rcd;
  logic        read_safe;
  logic        write_safe;
  logic [3:0]  precharge_safe;
  logic        read;
  logic        write;
  logic [3:0]  concerned_bank;
  logic        sdram_cs_n;
  logic        sdram_ras_n;
  logic        sdram_cas_n;
  logic        sdram_we_n;
  logic [12:0] sdram_adr;
  logic [1:0]  sdram_ba;

  logic [2:0]  cmd;
  int          checks = 0;
  int          errors = 0;
  int          act_cnt = 0, pre_cnt = 0, rd_cnt = 0, wr_cnt = 0, ack_cnt = 0;

  assign cmd = {sdram_ras_n, sdram_cas_n, sdram_we_n};

  hpdmc_cmdsched dut (
    .sys_clk        (sys_clk),
    .sdram_rst      (sdram_rst),
    .stb            (stb),
    .we             (we),
    .address        (address),
    .ack            (ack),
    .tim_rp         (tim_rp),
    .tim_rcd        (tim_rcd),
    .read_safe      (read_safe),
    .write_safe     (write_safe),
    .precharge_safe (precharge_safe),
    .read           (read),
    .write          (write),
    .concerned_bank (concerned_bank),
    .sdram_cs_n     (sdram_cs_n),
    .sdram_ras_n    (sdram_ras_n),
    .sdram_cas_n    (sdram_cas_n),
    .sdram_we_n     (sdram_we_n),
    .sdram_adr      (sdram_adr),
    .sdram_ba       (sdram_ba)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Tally every issued command and ack pulse between edges.
  always @(negedge sys_clk) begin
    if (!sdram_rst && !sdram_cs_n) begin
      case (cmd)
        CMD_ACT:   act_cnt++;
        CMD_PRE:   pre_cnt++;
        CMD_READ:  rd_cnt++;
        CMD_WRITE: wr_cnt++;
        default:   ;
      endcase
    end
    if (!sdram_rst && ack) ack_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  // Advance until a non-NOP command is on the bus; n = edges taken.
  task automatic wait_any(input string tag, input int budget, output int n);
    logic seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      step();
      n++;
      seen = !sdram_cs_n && (cmd != CMD_NOP);
    end
    if (!seen) check({tag, "_cmd_seen"}, 32'(seen), 32'd1);
  endtask

  int n;
  int a0, p0, r0, k0;

  initial begin
    sdram_rst      = 1'b1;
    stb            = 1'b0;
    we             = 1'b0;
    address        = '0;
    tim_rp         = 3'd2;
    tim_rcd        = 3'd2;
    read_safe      = 1'b1;
    write_safe     = 1'b1;
    precharge_safe = 4'hF;
    repeat (2) step();

    check("rst_cs_n",   32'(sdram_cs_n), 32'd1);
    check("rst_cmd",    32'(cmd), 32'(CMD_NOP));
    check("rst_adr",    32'(sdram_adr), 32'd0);
    check("rst_ba",     32'(sdram_ba), 32'd0);
    check("rst_ack",    32'({ack, read, write}), 32'd0);
    check("rst_cbank",  32'(concerned_bank), 32'd0);
    sdram_rst = 1'b0;

    // Closed bank 1: ACT then READ tim_rcd+2 later.
    step();
    stb = 1'b1; we = 1'b0; address = 23'h000105;
    wait_any("t1_act", 16, n);
    check("t1_act_lat", 32'(n), 32'd2);
    check("t1_act_cmd", 32'(cmd), 32'(CMD_ACT));
    check("t1_act_adr", 32'(sdram_adr), 32'h000);
    check("t1_act_ba",  32'(sdram_ba), 32'd1);
    wait_any("t1_rd", 16, n);
    check("t1_rd_gap",  32'(n), 32'd4);
    check("t1_rd_cmd",  32'(cmd), 32'(CMD_READ));
    check("t1_rd_adr",  32'(sdram_adr), 32'h005);
    check("t1_rd_ba",   32'(sdram_ba), 32'd1);
    check("t1_rd_pulses", 32'({ack, read, write}), 32'b110);
    check("t1_rd_cbank", 32'(concerned_bank), 32'b0010);
    stb = 1'b0;

    // Same row as a write: row hit, latency 2, no ACT.
    step();
    a0 = act_cnt;
    stb = 1'b1; we = 1'b1; address = 23'h000137;
    wait_any("t2_wr", 16, n);
    check("t2_wr_lat",  32'(n), 32'd2);
    check("t2_wr_cmd",  32'(cmd), 32'(CMD_WRITE));
    check("t2_wr_adr",  32'(sdram_adr), 32'h037);
    check("t2_wr_pulses", 32'({ack, read, write}), 32'b101);
    check("t2_wr_cbank", 32'(concerned_bank), 32'b0010);
    check("t2_no_act",  32'(act_cnt - a0), 32'd0);
    stb = 1'b0;

    // Row miss in bank 1 with precharge permission withheld.
    step();
    precharge_safe = 4'b1101;
    we = 1'b0; address = 23'h000D00; stb = 1'b1;
    p0 = pre_cnt;
    repeat (5) step();
    check("t3_pre_held", 32'(pre_cnt - p0), 32'd0);
    check("t3_nop",      32'({sdram_cs_n, cmd}), 32'({1'b0, CMD_NOP}));
    precharge_safe = 4'hF;
    wait_any("t3_pre", 16, n);
    check("t3_pre_lat",  32'(n), 32'd1);
    check("t3_pre_cmd",  32'(cmd), 32'(CMD_PRE));
    check("t3_pre_a10",  32'(sdram_adr[10]), 32'd0);
    check("t3_pre_ba",   32'(sdram_ba), 32'd1);
    wait_any("t3_act", 16, n);
    check("t3_act_gap",  32'(n), 32'd4);
    check("t3_act_cmd",  32'(cmd), 32'(CMD_ACT));
    check("t3_act_adr",  32'(sdram_adr), 32'h003);
    wait_any("t3_rd", 16, n);
    check("t3_rd_gap",   32'(n), 32'd4);
    check("t3_rd_cmd",   32'(cmd), 32'(CMD_READ));
    check("t3_rd_ack",   32'(ack), 32'd1);
    stb = 1'b0;

    // read_safe low for 8 cycles in ISSUE.
    step();
    read_safe = 1'b0;
    address = 23'h000D05; stb = 1'b1;
    r0 = rd_cnt; k0 = ack_cnt;
    repeat (9) step();
    check("t4_no_rd",    32'(rd_cnt - r0), 32'd0);
    check("t4_no_ack",   32'(ack_cnt - k0), 32'd0);
    check("t4_nop",      32'({sdram_cs_n, cmd}), 32'({1'b0, CMD_NOP}));
    read_safe = 1'b1;
    wait_any("t4_rd", 16, n);
    check("t4_rd_lat",   32'(n), 32'd1);
    check("t4_rd_cmd",   32'(cmd), 32'(CMD_READ));
    check("t4_rd_adr",   32'(sdram_adr), 32'h005);
    check("t4_rd_ack",   32'(ack), 32'd1);
    stb = 1'b0;

    // Reset while waiting tRCD on bank 2; table must come back empty.
    step();
    address = 23'h000200; stb = 1'b1;
    wait_any("t5_act", 16, n);
    check("t5_act_cmd",  32'(cmd), 32'(CMD_ACT));
    check("t5_act_ba",   32'(sdram_ba), 32'd2);
    step();
    sdram_rst = 1'b1;
    #1;
    check("t5_rst_cs_n", 32'(sdram_cs_n), 32'd1);
    check("t5_rst_state", 32'(dut.state), 32'(S_IDLE));
    check("t5_rst_ack",  32'(ack), 32'd0);
    tim_rcd = 3'd0;
    step();
    sdram_rst = 1'b0;
    wait_any("t5_react", 16, n);
    check("t5_react_lat", 32'(n), 32'd2);
    check("t5_react_cmd", 32'(cmd), 32'(CMD_ACT));
    check("t5_react_ba",  32'(sdram_ba), 32'd2);
    wait_any("t5_rd", 16, n);
    check("t5_rd_gap",   32'(n), 32'd2);
    check("t5_rd_cmd",   32'(cmd), 32'(CMD_READ));
    check("t5_rd_ack",   32'(ack), 32'd1);
    stb = 1'b0;

    // stb kept high across the edge where ack is high: one READ only.
    step();
    r0 = rd_cnt; k0 = ack_cnt;
    address = 23'h000206; stb = 1'b1;
    wait_any("t6_rd", 16, n);
    check("t6_rd_lat",   32'(n), 32'd2);
    check("t6_rd_cmd",   32'(cmd), 32'(CMD_READ));
    check("t6_rd_ack",   32'(ack), 32'd1);
    step();
    check("t6_ack_gone", 32'({ack, read}), 32'd0);
    check("t6_cbank_clr", 32'(concerned_bank), 32'd0);
    stb = 1'b0;
    repeat (8) step();
    check("t6_one_read", 32'(rd_cnt - r0), 32'd1);
    check("t6_one_ack",  32'(ack_cnt - k0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
